mcp3008_reader: RTL and testbench

//  SPI master for the MCP3008 10-bit ADC (accelerator pedal pot). Runs continuous

---
 rtl/mcp3008_reader_pkg.sv | 49 ++++
 rtl/mcp3008_reader_spi_tick_gen.sv | 39 +++
 rtl/mcp3008_reader.sv | 216 +++++++++++++++++++++
 tb/tb_mcp3008_reader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp3008_reader_pkg.sv
// mcp3008_pkg: state encoding, SPI frame constants and the accel mapping
// shared by the MCP3008 reader and its sub-blocks.
package mcp3008_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      SKIP,
      DATA,
      GAP
   } state_t;

   // Rising SCLK edges per frame section
   localparam int CMD_BITS    = 5;   // start, sgl/diff, d2, d1, d0
   localparam int SKIP_BITS   = 2;   // sample period + null bit
   localparam int DATA_BITS   = 10;  // B9..B0
   localparam int FRAME_EDGES = CMD_BITS + SKIP_BITS + DATA_BITS;

   // Edge counter must also hold FRAME_EDGES+1 (the "sample already issued" mark)
   localparam int EDGE_W = 5;

   // Working width of the mapper; wide enough that (1023-lo)*255 never wraps
   localparam int MAP_W = 18;

   // Clamped linear map of a raw conversion to an accel value.
   // raw <= lo gives 0, otherwise min((raw - lo) * gain, max_val).
   function automatic logic [DATA_BITS-1:0] map_accel(
      input logic [DATA_BITS-1:0] raw,
      input logic [DATA_BITS-1:0] lo,
      input logic [7:0]           gain,
      input logic [DATA_BITS-1:0] max_val
   );
      logic [MAP_W-1:0]     diff;
      logic [MAP_W-1:0]     prod;
      logic [DATA_BITS-1:0] res;
      // diff wraps when raw <= lo, but that branch never uses it
      diff = MAP_W'(raw) - MAP_W'(lo);
      prod = diff * MAP_W'(gain);
      if (raw <= lo) begin
         res = '0;
      end else if (prod > MAP_W'(max_val)) begin
         res = max_val;
      end else begin
         res = prod[DATA_BITS-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/mcp3008_reader_spi_tick_gen.sv
// spi_tick_gen: produces one tick every HALF_DIV clk cycles while run is high.
// The count is held at zero whenever run is low, so the first tick of a run
// always lands exactly HALF_DIV cycles after run rises.
module spi_tick_gen #(
   parameter int HALF_DIV = 14
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int            CW   = $clog2(HALF_DIV);
   localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: wrap at LAST while running, forced to zero when stopped
   always_comb begin
      cnt_d = '0;
      if (run) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   // Divider count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Tick on the last count of each SCLK half-period
   assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/mcp3008_reader.sv
// mcp3008_reader: SPI master that runs continuous MCP3008 conversion frames on
// a selected channel, captures each 10-bit result and maps it to a clamped,
// scaled accel value for the PWM duty stage. All outputs come from flops.
module mcp3008_reader
   import mcp3008_pkg::*;
#(
   parameter int HALF_DIV   = 14,
   parameter int GAP_CYCLES = 27,
   parameter int ACC_LO     = 280,
   parameter int ACC_GAIN   = 2,
   parameter int ACC_MAX    = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [2:0]           channel,
   input  logic                 single_ended,
   output logic                 adc_sclk,
   output logic                 adc_cs_n,
   output logic                 adc_din,
   input  logic                 adc_dout,
   output logic                 busy,
   output logic                 sample_valid,
   output logic [DATA_BITS-1:0] sample_data,
   output logic [2:0]           sample_channel,
   output logic [DATA_BITS-1:0] accel
);

   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [GW-1:0]     GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [EDGE_W-1:0] CMD_LAST  = EDGE_W'(CMD_BITS - 1);
   localparam logic [EDGE_W-1:0] SKIP_LAST = EDGE_W'(CMD_BITS + SKIP_BITS - 1);
   localparam logic [EDGE_W-1:0] ALL_RISEN = EDGE_W'(FRAME_EDGES);
   localparam logic [EDGE_W-1:0] SAMPLED   = EDGE_W'(FRAME_EDGES + 1);

   // FSM and frame bookkeeping
   state_t                state_q, state_d;
   logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
   logic [EDGE_W-1:0]     edge_cnt_q, edge_cnt_d;

   // SPI shift registers and frame-latched configuration
   logic [CMD_BITS-1:0]   cmd_q, cmd_d;
   logic [DATA_BITS-1:0]  rx_q, rx_d;
   logic [2:0]            ch_q, ch_d;

   // Registered outputs
   logic                  sclk_q, sclk_d;
   logic                  cs_n_q, cs_n_d;
   logic                  busy_q, busy_d;
   logic                  valid_q, valid_d;
   logic [DATA_BITS-1:0]  data_q, data_d;
   logic [2:0]            sch_q, sch_d;
   logic [DATA_BITS-1:0]  accel_q, accel_d;

   // Decoded frame events
   logic run;
   logic tick;
   logic rise;
   logic fall;
   logic gap_done;
   logic frame_start;
   logic frame_end;
   logic sample_now;

   // SCLK half-period timer runs only while chip select is asserted
   assign run = (state_q == CMD) || (state_q == SKIP) || (state_q == DATA);

   spi_tick_gen #(
      .HALF_DIV (HALF_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
      .tick (tick)
   );

   assign rise        = tick && !sclk_q;
   assign fall        = tick &&  sclk_q;
   assign gap_done    = (state_q == GAP) && (gap_cnt_q == GAP_LAST);
   assign frame_start = enable && ((state_q == IDLE) || gap_done);
   // Final falling edge comes only after the sample has been issued
   assign frame_end   = fall && (state_q == DATA) && (edge_cnt_q == SAMPLED);
   // One cycle after the last rising edge, publish the captured word
   assign sample_now  = (state_q == DATA) && (edge_cnt_q == ALL_RISEN);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: section boundaries are counted in rising SCLK edges
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (frame_start) state_d = CMD;
         end
         CMD: begin
            if (rise && (edge_cnt_q == CMD_LAST)) state_d = SKIP;
         end
         SKIP: begin
            if (rise && (edge_cnt_q == SKIP_LAST)) state_d = DATA;
         end
         DATA: begin
            if (frame_end) state_d = GAP;
         end
         GAP: begin
            if (gap_done) state_d = frame_start ? CMD : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values for the SPI pins, shifters and sample regs
   always_comb begin
      gap_cnt_d  = '0;
      edge_cnt_d = edge_cnt_q;
      cmd_d      = cmd_q;
      rx_d       = rx_q;
      ch_d       = ch_q;
      sclk_d     = sclk_q;
      cs_n_d     = cs_n_q;
      busy_d     = busy_q;
      valid_d    = 1'b0;
      data_d     = data_q;
      sch_d      = sch_q;
      accel_d    = accel_q;

      if (state_q == GAP) begin
         gap_cnt_d = gap_cnt_q + GW'(1);
      end

      if (frame_start) begin
         // Start bit goes on din together with the cs_n fall
         cs_n_d     = 1'b0;
         busy_d     = 1'b1;
         sclk_d     = 1'b0;
         edge_cnt_d = '0;
         rx_d       = '0;
         ch_d       = channel;
         cmd_d      = {1'b1, single_ended, channel};
      end else if (run) begin
         if (tick) begin
            sclk_d = ~sclk_q;
         end
         if (rise) begin
            edge_cnt_d = edge_cnt_q + EDGE_W'(1);
            if (state_q == DATA) begin
               rx_d = {rx_q[DATA_BITS-2:0], adc_dout};
            end
         end
         if (fall) begin
            // Next command bit (zeros once the command is exhausted)
            cmd_d = {cmd_q[CMD_BITS-2:0], 1'b0};
         end
         if (frame_end) begin
            cs_n_d = 1'b1;
            busy_d = 1'b0;
         end
         if (sample_now) begin
            valid_d    = 1'b1;
            edge_cnt_d = SAMPLED;
            data_d     = rx_q;
            sch_d      = ch_q;
            accel_d    = map_accel(rx_q, DATA_BITS'(ACC_LO), 8'(ACC_GAIN),
                                   DATA_BITS'(ACC_MAX));
         end
      end
   end

   // Datapath and output registers; reset aborts any frame in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_cnt_q  <= '0;
         edge_cnt_q <= '0;
         cmd_q      <= '0;
         rx_q       <= '0;
         ch_q       <= '0;
         sclk_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         sch_q      <= '0;
         accel_q    <= '0;
      end else begin
         gap_cnt_q  <= gap_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         cmd_q      <= cmd_d;
         rx_q       <= rx_d;
         ch_q       <= ch_d;
         sclk_q     <= sclk_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         sch_q      <= sch_d;
         accel_q    <= accel_d;
      end
   end

   assign adc_sclk       = sclk_q;
   assign adc_cs_n       = cs_n_q;
   assign adc_din        = cmd_q[CMD_BITS-1];
   assign busy           = busy_q;
   assign sample_valid   = valid_q;
   assign sample_data    = data_q;
   assign sample_channel = sch_q;
   assign accel          = accel_q;

endmodule

// File: tb/tb_mcp3008_reader.sv
// tb_mcp3008_reader: MCP3008 SPI model plus scoreboard for mcp3008_reader.
// Stimulus pushes each frame's vector into the ADC model queue and the
// expected-result queue; a monitor pops and compares on every sample_valid.
module tb_mcp3008_reader;

   localparam int HD      = 2;
   localparam int GAP     = 4;
   localparam int LOW_LEN = 34 * HD;
   localparam int PERIOD  = LOW_LEN + GAP;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [2:0] channel = 3'd0;
   logic       single_ended = 1'b1;
   logic       adc_sclk;
   logic       adc_cs_n;
   logic       adc_din;
   logic       adc_dout = 1'b0;
   logic       busy;
   logic       sample_valid;
   logic [9:0] sample_data;
   logic [2:0] sample_channel;
   logic [9:0] accel;

   mcp3008_reader #(
      .HALF_DIV   (HD),
      .GAP_CYCLES (GAP),
      .ACC_LO     (280),
      .ACC_GAIN   (2),
      .ACC_MAX    (1000)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .channel        (channel),
      .single_ended   (single_ended),
      .adc_sclk       (adc_sclk),
      .adc_cs_n       (adc_cs_n),
      .adc_din        (adc_din),
      .adc_dout       (adc_dout),
      .busy           (busy),
      .sample_valid   (sample_valid),
      .sample_data    (sample_data),
      .sample_channel (sample_channel),
      .accel          (accel)
   );

   always #5 clk = ~clk;

   // One frame: inputs, model raw value, and hand-computed expectations
   typedef struct packed {
      logic [2:0] ch;
      logic       se;
      logic [9:0] raw;
      logic [4:0] cmd;
      logic [9:0] acc;
   } vec_t;

   vec_t tbl [12];
   vec_t vec_q [$];
   vec_t exp_q [$];
   int   vt [$];

   int n_vec = 0;
   int n_err = 0;
   int n_valid = 0;
   int frames = 0;
   int cyc = 0;

   // ADC model state
   vec_t       cur;
   logic       m_pcsn = 1'b1;
   logic       m_psck = 1'b0;
   int         m_rises = 0;
   int         m_falls = 0;
   int         m_low = 0;
   int         m_high = 0;
   int         m_viol = 0;
   bit         m_after = 0;
   logic [4:0] m_cmd = 5'd0;

   task automatic chk(input string name, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic wait_fall(output bit ok);
      logic p;
      ok = 0;
      for (int k = 0; k < 400; k++) begin
         p = adc_cs_n;
         @(negedge clk);
         if (p && !adc_cs_n) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic wait_rises(input int n, output bit ok);
      ok = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (m_rises >= n) begin
            ok = 1;
            break;
         end
      end
   endtask

   // Back-to-back frames; inputs are scrambled in DATA to prove frame latching
   task automatic run_seq(input int first, input int n);
      bit ok;
      for (int i = 0; i < n; i++) begin
         channel      = tbl[first+i].ch;
         single_ended = tbl[first+i].se;
         vec_q.push_back(tbl[first+i]);
         exp_q.push_back(tbl[first+i]);
         enable = 1'b1;
         wait_fall(ok);
         chk("frame_start", int'(ok), 1);
         repeat (40) @(negedge clk);
         channel      = ~channel;
         single_ended = ~single_ended;
      end
      enable = 1'b0;
      repeat (PERIOD + 20) @(negedge clk);
   endtask

   // MCP3008 model: checks command bits and frame timing, drives dout after falls
   initial begin : adc_model
      forever begin
         @(negedge clk);
         if (rst) begin
            m_pcsn = 1'b1; m_psck = 1'b0; adc_dout = 1'b0;
            m_rises = 0; m_falls = 0; m_viol = 0; m_after = 0;
            m_high = 0; m_low = 0;
         end else begin
            if (adc_cs_n && adc_sclk) m_viol++;
            if (m_pcsn && !adc_cs_n) begin
               if (m_after) chk("gap_len_ge", int'(m_high >= GAP), 1);
               chk("sclk_low_while_cs_high", m_viol, 0);
               m_viol = 0;
               chk("frame_has_vector", int'(vec_q.size() > 0), 1);
               if (vec_q.size() > 0) cur = vec_q.pop_front();
               else cur = '0;
               m_rises = 0; m_falls = 0; m_low = 0; m_cmd = 5'd0;
               adc_dout = 1'b0;
               frames++;
            end
            if (!m_psck && adc_sclk) begin
               m_rises++;
               if (m_rises == 1) chk("first_rise_latency", m_low, HD);
               if (m_rises <= 5) m_cmd = {m_cmd[3:0], adc_din};
               if (m_rises == 5) chk("cmd_bits", m_cmd, cur.cmd);
            end
            if (m_psck && !adc_sclk) begin
               m_falls++;
               if (m_falls >= 7 && m_falls <= 16) adc_dout = cur.raw[16 - m_falls];
               else adc_dout = 1'b0;
            end
            if (!m_pcsn && adc_cs_n) begin
               chk("rises_per_frame", m_rises, 17);
               chk("cs_low_len", m_low, LOW_LEN);
               m_after = 1;
               m_high = 0;
            end
            if (adc_cs_n) m_high++;
            else m_low++;
            m_pcsn = adc_cs_n;
            m_psck = adc_sclk;
         end
      end
   end

   // Scoreboard monitor: pops one expectation per sample_valid pulse
   initial begin : monitor
      logic prev_v;
      vec_t e;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            prev_v = 1'b0;
         end else begin
            if (sample_valid) begin
               n_valid++;
               vt.push_back(cyc);
               $display("sample: ch=%0d data=%0d accel=%0d cycle=%0d",
                        sample_channel, sample_data, accel, cyc);
               chk("valid_single_cycle", int'(prev_v), 0);
               chk("valid_cs_low", int'(adc_cs_n), 0);
               chk("valid_busy", int'(busy), 1);
               chk("valid_after_17_rises", m_rises, 17);
               chk("expectation_pending", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("sample_data", sample_data, e.raw);
                  chk("sample_channel", sample_channel, e.ch);
                  chk("accel", accel, e.acc);
               end
            end
            prev_v = sample_valid;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bit ok;
      int nv0;
      int fr0;
      //            ch    se    raw       cmd        accel
      tbl[0]  = '{3'd2, 1'b1, 10'd677,  5'b11010, 10'd794};
      tbl[1]  = '{3'd0, 1'b1, 10'd100,  5'b11000, 10'd0};
      tbl[2]  = '{3'd7, 1'b0, 10'd280,  5'b10111, 10'd0};
      tbl[3]  = '{3'd1, 1'b1, 10'd281,  5'b11001, 10'd2};
      tbl[4]  = '{3'd4, 1'b0, 10'd780,  5'b10100, 10'd1000};
      tbl[5]  = '{3'd6, 1'b1, 10'd1023, 5'b11110, 10'd1000};
      tbl[6]  = '{3'd2, 1'b1, 10'd512,  5'b11010, 10'd464};
      tbl[7]  = '{3'd5, 1'b1, 10'd300,  5'b11101, 10'd40};
      tbl[8]  = '{3'd3, 1'b0, 10'd682,  5'b10011, 10'd804};
      tbl[9]  = '{3'd4, 1'b1, 10'd900,  5'b11100, 10'd1000};
      tbl[10] = '{3'd3, 1'b0, 10'd401,  5'b10011, 10'd242};
      tbl[11] = '{3'd6, 1'b0, 10'd555,  5'b10110, 10'd550};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_cs_n", int'(adc_cs_n), 1);
      chk("rst_sclk", int'(adc_sclk), 0);
      chk("rst_din", int'(adc_din), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(sample_valid), 0);
      chk("rst_data", sample_data, 0);
      chk("rst_channel", sample_channel, 0);
      chk("rst_accel", accel, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_cs_n", int'(adc_cs_n), 1);

      // Single frame, ch 2 single-ended
      run_seq(0, 1);

      // Mapping corners, mixed channels and modes
      run_seq(1, 5);

      // Three back-to-back frames with channel change mid-DATA
      vt.delete();
      run_seq(6, 3);
      chk("three_valid_pulses", vt.size(), 3);
      if (vt.size() == 3) begin
         chk("valid_spacing_1", vt[1] - vt[0], PERIOD);
         chk("valid_spacing_2", vt[2] - vt[1], PERIOD);
      end

      // Reset during data bit 5 aborts the frame; next frame is clean
      channel      = tbl[9].ch;
      single_ended = tbl[9].se;
      vec_q.push_back(tbl[9]);
      exp_q.push_back(tbl[9]);
      enable = 1'b1;
      wait_fall(ok);
      chk("abort_frame_start", int'(ok), 1);
      wait_rises(12, ok);
      chk("reach_data_bit5", int'(ok), 1);
      nv0 = n_valid;
      #2 rst = 1'b1;
      #1;
      chk("midrst_cs_n", int'(adc_cs_n), 1);
      chk("midrst_sclk", int'(adc_sclk), 0);
      chk("midrst_din", int'(adc_din), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_valid", int'(sample_valid), 0);
      chk("midrst_data", sample_data, 0);
      chk("midrst_channel", sample_channel, 0);
      chk("midrst_accel", accel, 0);
      if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
      channel      = tbl[10].ch;
      single_ended = tbl[10].se;
      vec_q.push_back(tbl[10]);
      exp_q.push_back(tbl[10]);
      repeat (3) @(negedge clk);
      chk("no_valid_during_abort", n_valid - nv0, 0);
      #2 rst = 1'b0;
      wait_fall(ok);
      chk("post_rst_frame_start", int'(ok), 1);
      enable = 1'b0;
      repeat (PERIOD + 20) @(negedge clk);
      chk("post_rst_one_valid", n_valid - nv0, 1);

      // enable drops at rising edge 3: frame completes, then stays idle
      nv0 = n_valid;
      fr0 = frames;
      channel      = tbl[11].ch;
      single_ended = tbl[11].se;
      vec_q.push_back(tbl[11]);
      exp_q.push_back(tbl[11]);
      enable = 1'b1;
      wait_fall(ok);
      chk("drop_frame_start", int'(ok), 1);
      wait_rises(3, ok);
      chk("reach_rise3", int'(ok), 1);
      enable = 1'b0;
      repeat (PERIOD + 80) @(negedge clk);
      chk("drop_one_valid", n_valid - nv0, 1);
      chk("drop_one_frame", frames - fr0, 1);
      chk("drop_idle_cs_n", int'(adc_cs_n), 1);
      chk("drop_idle_busy", int'(busy), 0);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
